// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, runs the imem req/rvalid handshake and
// presents the latched instruction plus decoded fields to the control unit.
//
// state    | meaning
// S_BOOT   | one idle cycle after reset before the first fetch
// S_REQ    | imem_req pulse, address = pc
// S_WAIT   | waiting for imem_rvalid, timeout counter running
// S_EXEC   | instr valid, waiting for ex_done to pick the next pc
// S_FAULT  | terminal until reset (misaligned target or imem timeout)
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        jump,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc,
  output logic [31:0] retired_count,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   retired_q, retired_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   next_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP;
      retired_q    <= 32'd0;
      fault_code_q <= 2'b00;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retired_q    <= retired_d;
      fault_code_q <= fault_code_d;
      cnt_q        <= cnt_d;
    end
  end

  // Redirect priority: JALR, then JAL, then taken branch, then sequential.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (jump && pc_src == 2'b10)
      next_pc = jalr_target & ~32'd1;
    else if (jump && pc_src == 2'b01)
      next_pc = branch_target;
    else if (branch && branch_taken)
      next_pc = branch_target;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retired_d    = retired_q;
    fault_code_d = fault_code_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            fault_code_d = 2'b10;
            state_d      = S_FAULT;
          end
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          retired_d = retired_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            fault_code_d = 2'b01;
            state_d      = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  assign imem_req      = (state_q == S_REQ);
  assign instr_valid   = (state_q == S_EXEC);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign retired_count = retired_q;
  assign fault         = (state_q == S_FAULT);
  assign fault_code    = fault_code_q;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump redirect, misaligned and
// timeout faults, reset during a fetch, and PC wrap on a second instance.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n, rst_w_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_done, branch, jump, branch_taken;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jalr_target;

  logic        imem_req, instr_valid, fault;
  logic [31:0] imem_addr, instr, pc, retired_count;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  fault_code;

  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_instr, w_pc, w_retired;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [1:0]  w_fault_code;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] W_ADD = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] W_SUB = 32'h40B5_0533; // sub x10,x10,x11
  localparam logic [31:0] W_BEQ = 32'h0020_8463;
  localparam logic [31:0] W_JAL = 32'h0000_006F;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ex_done(ex_done), .branch(branch), .jump(jump), .pc_src(pc_src),
    .branch_taken(branch_taken), .branch_target(branch_target), .jalr_target(jalr_target),
    .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc(pc), .retired_count(retired_count), .fault(fault), .fault_code(fault_code)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) dut_w (
    .clk(clk), .rst_n(rst_w_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ex_done(ex_done), .branch(branch), .jump(jump), .pc_src(pc_src),
    .branch_taken(branch_taken), .branch_target(branch_target), .jalr_target(jalr_target),
    .instr_valid(w_valid), .instr(w_instr),
    .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7), .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
    .pc(w_pc), .retired_count(w_retired), .fault(w_fault), .fault_code(w_fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with rst_n high (BOOT).
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !imem_req; i++) step();
    chk("req_seen", imem_req, 1'b1);
  endtask

  task automatic fetch_exec(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
    wait_req();
    chk("fetch_addr", imem_addr, exp_addr);
    repeat (lat) step();
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("instr_valid", instr_valid, 1'b1);
    chk("instr", instr, word);
    chk("pc", pc, exp_addr);
  endtask

  task automatic retire(input logic br, input logic tk, input logic jmp, input logic [1:0] src,
                        input logic [31:0] btgt, input logic [31:0] jtgt);
    step();
    chk("valid_held", instr_valid, 1'b1);
    ex_done       = 1'b1;
    branch        = br;
    branch_taken  = tk;
    jump          = jmp;
    pc_src        = src;
    branch_target = btgt;
    jalr_target   = jtgt;
    step();
    ex_done = 1'b0; branch = 1'b0; branch_taken = 1'b0; jump = 1'b0; pc_src = 2'b00;
    branch_target = 32'h0; jalr_target = 32'h0;
  endtask

  initial begin
    int req_cnt;
    rst_n = 1'b0; rst_w_n = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    ex_done = 1'b0; branch = 1'b0; jump = 1'b0; branch_taken = 1'b0; pc_src = 2'b00;
    branch_target = 32'h0; jalr_target = 32'h0;
    repeat (3) step();

    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_opcode", opcode, 7'h13);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired_count, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 2'b00);

    // Sequential fetch, latency 2, then a not-taken branch at pc=8.
    rst_n = 1'b1;
    chk("boot_req", imem_req, 1'b0);
    step();
    chk("first_req", imem_req, 1'b1);
    fetch_exec(32'h0, W_ADD, 2);
    chk("dec_opcode", opcode, 7'h13);
    chk("dec_rd", rd, 5'd1);
    chk("dec_funct3", funct3, 3'd0);
    retire(0, 0, 0, 2'b00, 32'h0, 32'h0);
    chk("ret_to_req", imem_req, 1'b1);
    chk("seq_addr1", imem_addr, 32'h4);
    chk("retired1", retired_count, 32'd1);
    fetch_exec(32'h4, W_SUB, 2);
    chk("dec_opcode2", opcode, 7'h33);
    chk("dec_funct7", funct7, 7'h20);
    chk("dec_rs1", rs1, 5'd10);
    chk("dec_rs2", rs2, 5'd11);
    chk("dec_rd2", rd, 5'd10);
    retire(0, 0, 0, 2'b00, 32'h0, 32'h0);
    fetch_exec(32'h8, W_BEQ, 2);
    retire(1, 0, 0, 2'b00, 32'h40, 32'h0);
    chk("nt_addr", imem_addr, 32'hC);
    chk("retired3", retired_count, 32'd3);

    // Taken branch, JALR (with priority over taken branch), misaligned JAL.
    do_reset();
    fetch_exec(32'h0, W_ADD, 1);
    retire(0, 0, 0, 2'b00, 32'h0, 32'h0);
    fetch_exec(32'h4, W_ADD, 1);
    retire(0, 0, 0, 2'b00, 32'h0, 32'h0);
    fetch_exec(32'h8, W_BEQ, 1);
    retire(1, 1, 0, 2'b00, 32'h40, 32'h0);
    chk("taken_addr", imem_addr, 32'h40);
    fetch_exec(32'h40, W_JAL, 1);
    retire(1, 1, 1, 2'b10, 32'h80, 32'h201);
    chk("jalr_addr", imem_addr, 32'h200);
    fetch_exec(32'h200, W_JAL, 1);
    retire(0, 0, 1, 2'b01, 32'h202, 32'h0);
    chk("mis_fault", fault, 1'b1);
    chk("mis_code", fault_code, 2'b01);
    chk("mis_pc", pc, 32'h200);
    chk("mis_retired", retired_count, 32'd5);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) req_cnt++;
      imem_rvalid = i[0];
      ex_done     = ~i[0];
      step();
    end
    imem_rvalid = 1'b0; ex_done = 1'b0;
    chk("fault_no_req", req_cnt, 0);
    chk("fault_pc_frozen", pc, 32'h200);
    chk("fault_instr_frozen", instr, W_JAL);
    chk("fault_no_valid", instr_valid, 1'b0);
    chk("fault_sticky", fault, 1'b1);

    // Timeout after 16 WAIT cycles.
    do_reset();
    wait_req();
    repeat (16) step();
    chk("to_not_yet", fault, 1'b0);
    step();
    chk("to_fault", fault, 1'b1);
    chk("to_code", fault_code, 2'b10);
    chk("to_req", imem_req, 1'b0);

    // Response on the 16th WAIT cycle wins.
    do_reset();
    wait_req();
    repeat (16) step();
    imem_rvalid = 1'b1; imem_rdata = W_SUB;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("late_no_fault", fault, 1'b0);
    chk("late_valid", instr_valid, 1'b1);
    chk("late_instr", instr, W_SUB);

    // Reset during WAIT, stale rvalid in BOOT is ignored.
    do_reset();
    wait_req();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("stale_valid", instr_valid, 1'b0);
    chk("stale_instr", instr, NOP);
    chk("stale_req", imem_req, 1'b1);
    chk("stale_addr", imem_addr, 32'h0);
    fetch_exec(32'h0, W_BEQ, 1);

    // PC wrap on the second instance.
    rst_n   = 1'b0;
    rst_w_n = 1'b1;
    step();
    chk("w_req", w_req, 1'b1);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b1; imem_rdata = W_ADD;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk("w_valid", w_valid, 1'b1);
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    chk("w_wrap_req", w_req, 1'b1);
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_no_fault", w_fault, 1'b0);
    chk("w_retired", w_retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
